mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access stage driving a valid/ok data bus.
// Define MEM_MISALIGN_CHECK_EN to trap unaligned accesses instead of aligning them.
module mem_access_stage #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_i,
   input  logic [4:0]        dst_i,
   input  logic              regwrite_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic              memread_i,
   input  logic              memwrite_i,
   input  logic [1:0]        msize_i,
   input  logic              unsigned_i,
   input  logic [XLEN-1:0]   sdata_i,
   input  logic              flush_i,
   output logic              dreq_valid,
   output logic [ADDR_W-1:0] dreq_addr,
   output logic [2:0]        dreq_size,
   output logic [XLEN/8-1:0] dreq_strobe,
   output logic [XLEN-1:0]   dreq_data,
   input  logic              dresp_ok,
   input  logic [XLEN-1:0]   dresp_data,
   output logic              stall_o,
   output logic              valid_o,
   output logic [4:0]        dst_o,
   output logic              regwrite_o,
   output logic [XLEN-1:0]   wdata_o,
   output logic              misalign_o
);
   localparam int STRB_W = XLEN / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0] state, state_nx;

   logic [ADDR_W-1:0] l_addr;
   logic [2:0]        l_size;
   logic [STRB_W-1:0] l_strobe;
   logic [XLEN-1:0]   l_data;
   logic [4:0]        l_dst;
   logic              l_rw, l_load, l_uns;
   logic [XLEN-1:0]   l_wdata;
   logic [1:0]        l_esz;
   logic [OFF_W-1:0]  l_off;

   logic [1:0]        esz;
   logic [2:0]        low_m;
   logic [ADDR_W-1:0] addr_raw, addr_c;
   logic [OFF_W-1:0]  off;
   logic [STRB_W-1:0] lane_m, strobe;
   logic [XLEN-1:0]   rep, sdata_a;
   logic              mem_op, mis, go, trap, idle;

   always_comb begin
      // XLEN=32 has no doubleword; msize 3 behaves as a word
      esz = (XLEN == 32 && msize_i == 2'd3) ? 2'd2 : msize_i;
      unique case (esz)
         2'd0:    low_m = 3'b000;
         2'd1:    low_m = 3'b001;
         2'd2:    low_m = 3'b011;
         default: low_m = 3'b111;
      endcase
      addr_raw = ADDR_W'(wdata_i);
      mem_op = memread_i | memwrite_i;
`ifdef MEM_MISALIGN_CHECK_EN
      mis    = mem_op & (|(addr_raw[2:0] & low_m));
      addr_c = addr_raw;
`else
      mis    = 1'b0;
      addr_c = addr_raw & ~ADDR_W'(low_m);
`endif
      off    = addr_c[OFF_W-1:0];
      lane_m = ~({STRB_W{1'b1}} << (1 << esz));
      strobe = memwrite_i ? (lane_m << off) : '0;
      unique case (esz)
         2'd0:    rep = {STRB_W{sdata_i[7:0]}};
         2'd1:    rep = {(STRB_W/2){sdata_i[15:0]}};
         2'd2:    rep = {(STRB_W/4){sdata_i[31:0]}};
         default: rep = sdata_i;
      endcase
      sdata_a = rep << {off, 3'b000};
      go   = valid_i & ~flush_i & mem_op & ~mis;
      trap = valid_i & ~flush_i & mis;
      idle = state == IDLE;
   end

   always_comb begin
      dreq_valid  = ~reset & (idle ? go : 1'b1);
      dreq_addr   = idle ? addr_c : l_addr;
      dreq_size   = idle ? {1'b0, msize_i} : l_size;
      dreq_strobe = idle ? strobe : l_strobe;
      dreq_data   = idle ? sdata_a : l_data;
      stall_o     = dreq_valid & ~dresp_ok;
   end

   logic              a_uns;
   logic [1:0]        a_esz;
   logic [OFF_W-1:0]  a_off;
   logic [XLEN-1:0]   sh, ld_mask, ld_res;

   always_comb begin
      a_uns = idle ? unsigned_i : l_uns;
      a_esz = idle ? esz : l_esz;
      a_off = idle ? off : l_off;
      sh      = dresp_data >> {a_off, 3'b000};
      ld_mask = {XLEN{1'b1}} >> (XLEN - (8 << a_esz));
      ld_res  = sh & ld_mask;
      if (!a_uns && sh[(8 << a_esz) - 1])
         ld_res = ld_res | ~ld_mask;
   end

   logic              done;
   logic [4:0]        nx_dst;
   logic              nx_rw;
   logic [XLEN-1:0]   nx_wdata;

   always_comb begin
      state_nx = state;
      done     = 1'b0;
      nx_dst   = dst_i;
      nx_rw    = regwrite_i;
      nx_wdata = wdata_i;
      unique case (state)
         IDLE: begin
            if (go && !dresp_ok)
               state_nx = BUSY;
            if (valid_i && !flush_i) begin
               if (!mem_op) begin
                  done = 1'b1;
               end else if (trap) begin
                  done  = 1'b1;
                  nx_rw = 1'b0;
               end else if (dresp_ok) begin
                  done = 1'b1;
                  if (memread_i)
                     nx_wdata = ld_res;
               end
            end
         end
         BUSY: begin
            nx_dst   = l_dst;
            nx_rw    = l_rw;
            nx_wdata = l_load ? ld_res : l_wdata;
            if (dresp_ok) begin
               state_nx = IDLE;
               done     = ~flush_i;
            end else if (flush_i) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (dresp_ok)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         l_addr     <= '0;
         l_size     <= '0;
         l_strobe   <= '0;
         l_data     <= '0;
         l_dst      <= '0;
         l_rw       <= 1'b0;
         l_load     <= 1'b0;
         l_uns      <= 1'b0;
         l_wdata    <= '0;
         l_esz      <= '0;
         l_off      <= '0;
         valid_o    <= 1'b0;
         dst_o      <= '0;
         regwrite_o <= 1'b0;
         wdata_o    <= '0;
      end else begin
         state <= state_nx;
         if (idle && go) begin
            l_addr   <= addr_c;
            l_size   <= {1'b0, msize_i};
            l_strobe <= strobe;
            l_data   <= sdata_a;
            l_dst    <= dst_i;
            l_rw     <= regwrite_i;
            l_load   <= memread_i;
            l_uns    <= unsigned_i;
            l_wdata  <= wdata_i;
            l_esz    <= esz;
            l_off    <= off;
         end
         valid_o <= done;
         if (done) begin
            dst_o      <= nx_dst;
            regwrite_o <= nx_rw;
            wdata_o    <= nx_wdata;
         end
      end
   end

`ifdef MEM_MISALIGN_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         misalign_o <= 1'b0;
      else if (done)
         misalign_o <= idle & trap;
   end
`else
   assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed bench with a writeback scoreboard.
`timescale 1ns/1ps
module tb_mem_access_stage;
   localparam int XLEN   = 64;
   localparam int ADDR_W = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              valid_i, regwrite_i, memread_i, memwrite_i;
   logic              unsigned_i, flush_i, dresp_ok;
   logic [4:0]        dst_i;
   logic [1:0]        msize_i;
   logic [XLEN-1:0]   wdata_i, sdata_i, dresp_data;
   logic              dreq_valid, stall_o, valid_o, regwrite_o, misalign_o;
   logic [ADDR_W-1:0] dreq_addr;
   logic [2:0]        dreq_size;
   logic [XLEN/8-1:0] dreq_strobe;
   logic [XLEN-1:0]   dreq_data, wdata_o;
   logic [4:0]        dst_o;

   always #5 clk = ~clk;

   mem_access_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .dst_i(dst_i),
      .regwrite_i(regwrite_i), .wdata_i(wdata_i), .memread_i(memread_i),
      .memwrite_i(memwrite_i), .msize_i(msize_i), .unsigned_i(unsigned_i),
      .sdata_i(sdata_i), .flush_i(flush_i), .dreq_valid(dreq_valid),
      .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_ok(dresp_ok), .dresp_data(dresp_data), .stall_o(stall_o),
      .valid_o(valid_o), .dst_o(dst_o), .regwrite_o(regwrite_o),
      .wdata_o(wdata_o), .misalign_o(misalign_o)
   );

   typedef struct packed {
      logic [4:0]  dst;
      logic        rw;
      logic [63:0] wdata;
      logic        mis;
   } wb_t;

   wb_t sb[$];
   int  n_vec = 0;
   int  n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      valid_i = 0; dst_i = 0; regwrite_i = 0; wdata_i = 0;
      memread_i = 0; memwrite_i = 0; msize_i = 0; unsigned_i = 0;
      sdata_i = 0; flush_i = 0; dresp_ok = 0; dresp_data = 0;
   endtask

   task automatic op(input logic [4:0] dst, input logic rw,
                     input logic [63:0] wd, input logic rd,
                     input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [63:0] sd);
      valid_i = 1; dst_i = dst; regwrite_i = rw; wdata_i = wd;
      memread_i = rd; memwrite_i = wr; msize_i = sz;
      unsigned_i = uns; sdata_i = sd; flush_i = 0;
   endtask

   // Every writeback must match the oldest expected entry
   always @(negedge clk) begin
      wb_t e;
      if (!reset && valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid_o", 64'(valid_o), 64'h0);
         end else begin
            e = sb.pop_front();
            chk("wb_dst", 64'(dst_o), 64'(e.dst));
            chk("wb_regwrite", 64'(regwrite_o), 64'(e.rw));
            chk("wb_wdata", wdata_o, e.wdata);
            chk("wb_misalign", 64'(misalign_o), 64'(e.mis));
         end
      end
   end

   initial begin
      idle_in();
      #1;
      chk("rst_valid_o", 64'(valid_o), 64'h0);
      chk("rst_dreq_valid", 64'(dreq_valid), 64'h0);
      chk("rst_stall", 64'(stall_o), 64'h0);
      chk("rst_wdata_o", wdata_o, 64'h0);
      @(negedge clk);
      reset = 0;

      // ALU passthrough
      @(negedge clk);
      op(5'd5, 1'b1, 64'h1234, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
      sb.push_back('{5'd5, 1'b1, 64'h1234, 1'b0});
      #1;
      chk("pt_dreq_valid", 64'(dreq_valid), 64'h0);
      chk("pt_stall", 64'(stall_o), 64'h0);
      @(negedge clk);
      idle_in();
      #1;
      chk("pt_valid_o", 64'(valid_o), 64'h1);
      chk("pt_dreq_after", 64'(dreq_valid), 64'h0);

      // zero-wait LB / LBU at 0x1003, byte lane 3 holds 0x80
      @(negedge clk);
      op(5'd7, 1'b1, 64'h1003, 1'b1, 1'b0, 2'd0, 1'b0, 64'h0);
      dresp_ok = 1; dresp_data = 64'h0000_0000_8000_0000;
      sb.push_back('{5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0});
      #1;
      chk("lb_dreq_valid", 64'(dreq_valid), 64'h1);
      chk("lb_stall", 64'(stall_o), 64'h0);
      chk("lb_addr", dreq_addr, 64'h1003);
      chk("lb_size", 64'(dreq_size), 64'h0);
      chk("lb_strobe", 64'(dreq_strobe), 64'h0);
      @(negedge clk);
      unsigned_i = 1; dst_i = 5'd8;
      sb.push_back('{5'd8, 1'b1, 64'h80, 1'b0});
      #1;
      chk("lb_wdata_o", wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
      @(negedge clk);
      idle_in();
      #1;
      chk("lbu_wdata_o", wdata_o, 64'h80);

      // SH 0xBEEF at 0x2006, ok after 3 wait cycles
      @(negedge clk);
      op(5'd9, 1'b0, 64'h2006, 1'b0, 1'b1, 2'd1, 1'b0, 64'hBEEF);
      sb.push_back('{5'd9, 1'b0, 64'h2006, 1'b0});
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sh_stall", 64'(stall_o), 64'h1);
         chk("sh_dreq_valid", 64'(dreq_valid), 64'h1);
         chk("sh_addr", dreq_addr, 64'h2006);
         chk("sh_size", 64'(dreq_size), 64'h1);
         chk("sh_strobe", 64'(dreq_strobe), 64'hC0);
         chk("sh_data", 64'(dreq_data[63:48]), 64'hBEEF);
         chk("sh_wait_valid_o", 64'(valid_o), 64'h0);
         @(negedge clk);
         wdata_i = 64'hDEAD_0000; sdata_i = 64'h0; msize_i = 2'd0;
      end
      dresp_ok = 1;
      #1;
      chk("sh_ok_stall", 64'(stall_o), 64'h0);
      chk("sh_ok_strobe", 64'(dreq_strobe), 64'hC0);
      chk("sh_ok_addr", dreq_addr, 64'h2006);
      @(negedge clk);
      idle_in();
      #1;
      chk("sh_valid_o", 64'(valid_o), 64'h1);

      // LD outstanding, flushed after one cycle
      @(negedge clk);
      op(5'd10, 1'b1, 64'h3000, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0);
      #1;
      chk("fl_dreq0", 64'(dreq_valid), 64'h1);
      chk("fl_stall0", 64'(stall_o), 64'h1);
      @(negedge clk);
      flush_i = 1;
      #1;
      chk("fl_dreq1", 64'(dreq_valid), 64'h1);
      @(negedge clk);
      idle_in();
      #1;
      chk("fl_drain_dreq", 64'(dreq_valid), 64'h1);
      chk("fl_drain_addr", dreq_addr, 64'h3000);
      chk("fl_drain_stall", 64'(stall_o), 64'h1);
      @(negedge clk);
      dresp_ok = 1; dresp_data = 64'h5555;
      #1;
      chk("fl_ok_stall", 64'(stall_o), 64'h0);
      @(negedge clk);
      idle_in();
      #1;
      chk("fl_no_valid_o", 64'(valid_o), 64'h0);
      chk("fl_idle_dreq", 64'(dreq_valid), 64'h0);
      op(5'd11, 1'b1, 64'h77, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
      sb.push_back('{5'd11, 1'b1, 64'h77, 1'b0});
      @(negedge clk);
      idle_in();
      #1;
      chk("fl_then_pt", 64'(valid_o), 64'h1);

      // flush while idle: nothing issued, nothing written back
      @(negedge clk);
      op(5'd12, 1'b1, 64'h5000, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0);
      flush_i = 1; dresp_ok = 1;
      #1;
      chk("fli_dreq", 64'(dreq_valid), 64'h0);
      @(negedge clk);
      idle_in();
      #1;
      chk("fli_valid_o", 64'(valid_o), 64'h0);

      // LW at 0x1002
      @(negedge clk);
      op(5'd13, 1'b1, 64'h1002, 1'b1, 1'b0, 2'd2, 1'b0, 64'h0);
      dresp_ok = 1; dresp_data = 64'hCAFE_BABE_8765_4321;
`ifdef MEM_MISALIGN_CHECK_EN
      sb.push_back('{5'd13, 1'b0, 64'h1002, 1'b1});
      #1;
      chk("mis_dreq", 64'(dreq_valid), 64'h0);
      chk("mis_stall", 64'(stall_o), 64'h0);
      @(negedge clk);
      idle_in();
      #1;
      chk("mis_flag", 64'(misalign_o), 64'h1);
`else
      sb.push_back('{5'd13, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b0});
      #1;
      chk("mis_dreq", 64'(dreq_valid), 64'h1);
      chk("mis_addr", dreq_addr, 64'h1000);
      @(negedge clk);
      idle_in();
      #1;
      chk("mis_flag", 64'(misalign_o), 64'h0);
`endif

      // reset while BUSY, then a fresh LD
      @(negedge clk);
      op(5'd14, 1'b1, 64'h4000, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0);
      #1;
      chk("rb_dreq", 64'(dreq_valid), 64'h1);
      @(negedge clk);
      reset = 1;
      #1;
      chk("rb_dreq_rst", 64'(dreq_valid), 64'h0);
      chk("rb_stall_rst", 64'(stall_o), 64'h0);
      chk("rb_valid_o_rst", 64'(valid_o), 64'h0);
      chk("rb_wdata_o_rst", wdata_o, 64'h0);
      chk("rb_dst_o_rst", 64'(dst_o), 64'h0);
      @(negedge clk);
      reset = 0;
      idle_in();
      @(negedge clk);
      op(5'd15, 1'b1, 64'h4008, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0);
      sb.push_back('{5'd15, 1'b1, 64'h1122_3344_5566_7788, 1'b0});
      #1;
      chk("rb_new_stall", 64'(stall_o), 64'h1);
      chk("rb_new_addr", dreq_addr, 64'h4008);
      @(negedge clk);
      dresp_ok = 1; dresp_data = 64'h1122_3344_5566_7788;
      #1;
      chk("rb_new_ok_stall", 64'(stall_o), 64'h0);
      @(negedge clk);
      idle_in();
      #1;
      chk("rb_new_valid_o", 64'(valid_o), 64'h1);

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
